// File: rtl/enc_backend_seq.sv
// Kyber512 encryption back-end sequencer: launches INTT, State_Add and Compress
// in order with single-cycle enables, watchdogs each stage, supports abort with
// drain, and reports run length and error cause.
module enc_backend_seq #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int WD_W        = 13,
    parameter int RUN_W       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       skip_mask,
    output logic             intt_enable,
    input  logic             intt_done,
    output logic             add_enable,
    input  logic             add_done,
    output logic             comp_enable,
    input  logic             comp_done,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [1:0]       cur_stage,
    output logic [RUN_W-1:0] run_cycles
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DRAIN, S_FINISH, S_ERROR} state_t;

    localparam logic [2:0] CODE_ABORT = 3'd4;
    localparam logic [2:0] CODE_SPUR  = 3'd5;

    // First unskipped stage strictly after cur (0 = none left).
    function automatic logic [1:0] f_next(input logic [1:0] cur, input logic [2:0] mask);
        if (cur == 2'd0 && !mask[0]) return 2'd1;
        if (cur <= 2'd1 && !mask[1]) return 2'd2;
        if (cur <= 2'd2 && !mask[2]) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [2:0] f_onehot(input logic [1:0] stage);
        case (stage)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    state_t             r_state, w_state;
    logic [1:0]         r_stage, w_stage;
    logic [2:0]         r_mask,  w_mask;
    logic [WD_W-1:0]    r_wd,    w_wd;
    logic [RUN_W-1:0]   r_cnt,   w_cnt;
    logic [2:0]         r_en,    w_en;
    logic               r_busy,  w_busy;
    logic               r_done,  w_done;
    logic               r_err,   w_err;
    logic [2:0]         r_code,  w_code;
    logic [RUN_W-1:0]   r_run,   w_run;

    logic [2:0]         w_dones;
    logic [2:0]         w_act_bit;
    logic               w_act_done;
    logic               w_spur;
    logic               w_wd_exp;
    logic [1:0]         w_first;
    logic [1:0]         w_nxt;
    logic [RUN_W-1:0]   w_cnt_inc;
    logic               w_drain;

    assign w_dones    = {comp_done, add_done, intt_done};
    assign w_act_bit  = f_onehot(r_stage);
    assign w_act_done = |(w_dones & w_act_bit);
    assign w_spur     = |(w_dones & ~w_act_bit);
    assign w_wd_exp   = (r_wd == WD_W'(TIMEOUT_CYC - 1));
    assign w_first    = f_next(2'd0, skip_mask);
    assign w_nxt      = f_next(r_stage, r_mask);
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + RUN_W'(1);

    // Next-state and registered-output values. FINISH and ERROR last one
    // cycle and accept a new start exactly like IDLE.
    always_comb begin
        w_state = r_state;
        w_stage = r_stage;
        w_mask  = r_mask;
        w_wd    = r_wd;
        w_cnt   = r_cnt;
        w_en    = '0;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_err   = r_err;
        w_code  = r_code;
        w_run   = r_run;
        w_drain = 1'b0;
        case (r_state)
            S_IDLE, S_FINISH, S_ERROR: begin
                w_state = S_IDLE;
                if (start && !abort) begin
                    w_mask = skip_mask;
                    w_err  = 1'b0;
                    w_code = '0;
                    if (w_first != 2'd0) begin
                        w_state = S_WAIT;
                        w_stage = w_first;
                        w_en    = f_onehot(w_first);
                        w_busy  = 1'b1;
                        w_wd    = '0;
                        w_cnt   = RUN_W'(1);
                    end else begin
                        w_state = S_FINISH;
                        w_done  = 1'b1;
                        w_run   = RUN_W'(1);
                    end
                end
            end
            S_WAIT, S_DRAIN: begin
                w_wd    = r_wd + WD_W'(1);
                w_cnt   = w_cnt_inc;
                // Abort takes effect in the cycle it is seen, so a done in
                // that same cycle already completes the drain.
                w_drain = (r_state == S_DRAIN) || abort;
                if (w_act_done && !w_drain) begin
                    if (w_nxt != 2'd0) begin
                        w_state = S_WAIT;
                        w_stage = w_nxt;
                        w_en    = f_onehot(w_nxt);
                        w_wd    = '0;
                    end else begin
                        w_state = S_FINISH;
                        w_done  = 1'b1;
                        w_busy  = 1'b0;
                        w_stage = 2'd0;
                        w_run   = w_cnt_inc;
                    end
                end else if (w_act_done || w_spur || w_wd_exp) begin
                    w_state = S_ERROR;
                    w_err   = 1'b1;
                    w_busy  = 1'b0;
                    w_stage = 2'd0;
                    if (w_act_done)  w_code = CODE_ABORT;
                    else if (w_spur) w_code = CODE_SPUR;
                    else if (w_drain) w_code = CODE_ABORT;
                    else             w_code = {1'b0, r_stage};
                end else if (w_drain) begin
                    w_state = S_DRAIN;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_mask  <= '0;
            r_wd    <= '0;
            r_cnt   <= '0;
            r_en    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_code  <= '0;
            r_run   <= '0;
        end else begin
            r_state <= w_state;
            r_stage <= w_stage;
            r_mask  <= w_mask;
            r_wd    <= w_wd;
            r_cnt   <= w_cnt;
            r_en    <= w_en;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
            r_code  <= w_code;
            r_run   <= w_run;
        end
    end

    assign intt_enable = r_en[0];
    assign add_enable  = r_en[1];
    assign comp_enable = r_en[2];
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_code;
    assign cur_stage   = r_stage;
    assign run_cycles  = r_run;

endmodule

// File: tb/tb_enc_backend_seq.sv
// Self-checking bench for enc_backend_seq: directed scenarios plus random runs
// compared cycle by cycle against a timeline model built from the stage rules.
module tb_enc_backend_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort;
    logic [2:0] skip_mask;
    logic       intt_done, add_done, comp_done;

    logic        intt_enable, add_enable, comp_enable, busy, done, err;
    logic [2:0]  err_code;
    logic [1:0]  cur_stage;
    logic [19:0] run_cycles;

    logic        b_intt_en, b_add_en, b_comp_en, b_busy, b_done, b_err;
    logic [2:0]  b_code;
    logic [1:0]  b_stage;
    logic [3:0]  b_run;

    enc_backend_seq #(.TIMEOUT_CYC(8), .WD_W(4), .RUN_W(20)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .skip_mask(skip_mask),
        .intt_enable(intt_enable), .intt_done(intt_done),
        .add_enable(add_enable), .add_done(add_done),
        .comp_enable(comp_enable), .comp_done(comp_done),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .cur_stage(cur_stage), .run_cycles(run_cycles)
    );

    // Narrow run counter instance to exercise saturation; same stimulus.
    enc_backend_seq #(.TIMEOUT_CYC(8), .WD_W(4), .RUN_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .skip_mask(skip_mask),
        .intt_enable(b_intt_en), .intt_done(intt_done),
        .add_enable(b_add_en), .add_done(add_done),
        .comp_enable(b_comp_en), .comp_done(comp_done),
        .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_code),
        .cur_stage(b_stage), .run_cycles(b_run)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int run_id = 0;

    logic        prev_err;
    logic [2:0]  prev_code;
    logic [19:0] prev_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outs(input int c, input logic [2:0] x_en, input logic x_busy,
                              input logic x_done, input logic x_err, input logic [2:0] x_code,
                              input logic [1:0] x_stg, input logic [19:0] x_run);
        string p;
        p = $sformatf("run%0d.c%0d.", run_id, c);
        chk({p, "enables"}, 32'({comp_enable, add_enable, intt_enable}), 32'(x_en));
        chk({p, "busy"}, 32'(busy), 32'(x_busy));
        chk({p, "done"}, 32'(done), 32'(x_done));
        chk({p, "err"}, 32'(err), 32'(x_err));
        chk({p, "err_code"}, 32'(err_code), 32'(x_code));
        chk({p, "cur_stage"}, 32'(cur_stage), 32'(x_stg));
        chk({p, "run_cycles"}, 32'(run_cycles), 32'(x_run));
        chk({p, "run_sat4"}, 32'(b_run), (x_run > 20'd15) ? 32'd15 : 32'(x_run));
        chk({p, "ctl4"}, 32'({b_comp_en, b_add_en, b_intt_en, b_busy, b_done, b_err, b_code, b_stage}),
            32'({x_en, x_busy, x_done, x_err, x_code, x_stg}));
    endtask

    // lat >= 8 means the stage never reports done; ab/spc = 0 means none.
    task automatic run_seq(input logic [2:0] mask, input int l0, input int l1, input int l2,
                           input int ab, input int spc, input logic [2:0] spb);
        logic [2:0] drv[64];
        logic [2:0] een[64];
        logic       ebusy[64];
        logic [1:0] estg[64];
        int lat[3];
        int t, e, c, lim, endc, code;
        logic drn;
        logic       x_err, x_done;
        logic [2:0] x_code;
        logic [19:0] x_run;
        lat = '{l0, l1, l2};
        for (int i = 0; i < 64; i++) begin
            drv[i] = '0; een[i] = '0; ebusy[i] = 1'b0; estg[i] = '0;
        end
        if (spc > 0) drv[spc] = spb;
        t = 0;
        code = 0;
        c = 0;
        for (int s = 1; s <= 3 && code == 0; s++) begin
            if (mask[s-1]) continue;
            e = t + 1;
            een[e][s-1] = 1'b1;
            if (lat[s-1] < 8) drv[e + lat[s-1]][s-1] = 1'b1;
            lim = e + 7;
            for (c = e; c <= lim; c++) begin
                ebusy[c] = 1'b1;
                estg[c] = 2'(s);
                drn = (ab > 0 && c >= ab);
                if (drv[c][s-1]) begin
                    if (drn) code = 4;
                    break;
                end
                if ((drv[c] & ~(3'b001 << (s - 1))) != 3'b000) begin
                    code = 5;
                    break;
                end
                if (c == lim) begin
                    code = drn ? 4 : s;
                    break;
                end
            end
            t = c;
        end
        endc = t;

        for (int k = 0; k <= endc + 2; k++) begin
            @(posedge clk); #1;
            start = (k == 0);
            skip_mask = mask;
            abort = (ab > 0 && k == ab);
            {comp_done, add_done, intt_done} = drv[k];
            if (k == 0) begin
                x_err = prev_err; x_code = prev_code;
            end else if (k <= endc) begin
                x_err = 1'b0; x_code = '0;
            end else begin
                x_err = (code != 0); x_code = 3'(code);
            end
            x_done = (k == endc + 1) && (code == 0);
            x_run = (k > endc && code == 0) ? 20'(endc + 1) : prev_run;
            check_outs(k, een[k], ebusy[k], x_done, x_err, x_code, estg[k], x_run);
        end
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        {comp_done, add_done, intt_done} = '0;
        prev_err = (code != 0);
        prev_code = 3'(code);
        if (code == 0) prev_run = 20'(endc + 1);
        run_id++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; skip_mask = '0;
        intt_done = 1'b0; add_done = 1'b0; comp_done = 1'b0;
        prev_err = 1'b0; prev_code = '0; prev_run = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outs(0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 20'd0);
        rst = 1'b0;
        run_id = 1;

        // Full run: dones at 5/10/15, done pulse and run_cycles 16 (saturates to 15 in 4-bit copy).
        run_seq(3'b000, 4, 4, 4, 0, 0, 3'b000);
        // Only ADD runs, done at 4 -> pulse at 5.
        run_seq(3'b101, 0, 3, 0, 0, 0, 3'b000);
        // All stages skipped: done at 1.
        run_seq(3'b111, 0, 0, 0, 0, 0, 3'b000);
        // INTT timeout: err code 1 at cycle 9.
        run_seq(3'b000, 9, 0, 0, 0, 0, 3'b000);
        // Following start clears err.
        run_seq(3'b000, 2, 3, 1, 0, 0, 3'b000);
        // Abort at 8 during ADD, add_done at 12 -> code 4 at 13.
        run_seq(3'b000, 4, 6, 4, 8, 0, 3'b000);
        // add_done in the watchdog's last cycle still advances.
        run_seq(3'b000, 4, 7, 4, 0, 0, 3'b000);
        // intt_done during ADD -> spurious code 5.
        run_seq(3'b000, 4, 6, 4, 0, 8, 3'b001);
        // Spurious bit coinciding with the active done is just a done.
        run_seq(3'b000, 4, 3, 2, 0, 9, 3'b010);

        // start + abort in IDLE launch nothing; a done in IDLE is ignored.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0;
            intt_done = (k == 1);
            check_outs(k, 3'b000, 1'b0, 1'b0, prev_err, prev_code, 2'd0, prev_run);
        end
        intt_done = 1'b0;
        run_id++;

        // Reset mid-ADD, then restart.
        run_seq(3'b000, 1, 1, 1, 0, 0, 3'b000);
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            start = (k == 0 || k == 9);
            skip_mask = '0;
            intt_done = (k == 5);
            rst = (k == 7 || k == 11);
            if (k == 6) check_outs(k, 3'b010, 1'b1, 1'b0, 1'b0, 3'd0, 2'd2, prev_run);
            if (k == 8 || k == 12) check_outs(k, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 20'd0);
            if (k == 10) check_outs(k, 3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 20'd0);
        end
        rst = 1'b0; start = 1'b0; intt_done = 1'b0;
        prev_err = 1'b0; prev_code = '0; prev_run = '0;
        run_id++;

        // Randomized runs.
        for (int r = 0; r < 24; r++) begin
            logic [2:0] m, sb;
            int a0, a1, a2, ab, sc;
            m  = 3'($urandom % 8);
            a0 = int'($urandom % 10);
            a1 = int'($urandom % 10);
            a2 = int'($urandom % 10);
            ab = ($urandom % 4 == 0) ? int'(1 + $urandom % 20) : 0;
            sc = ($urandom % 4 == 0) ? int'(1 + $urandom % 20) : 0;
            sb = 3'b001 << ($urandom % 3);
            run_seq(m, a0, a1, a2, ab, sc, sb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
